// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and constants for the snake engine
// Holds the direction and state enums, PS/2 scancodes, the empty-slot
// marker and the initial snake placement used on reset and restart.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam logic [31:0] EMPTY_SLOT = 32'hFFFF_FFFF;

  localparam logic [7:0]  INIT_LEN = 8'd3;
  localparam logic [31:0] INIT_X0  = 32'd4;
  localparam logic [31:0] INIT_X1  = 32'd3;
  localparam logic [31:0] INIT_X2  = 32'd2;
  localparam logic [31:0] INIT_Y   = 32'd5;

  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      DIR_UP:   reverse_dir = DIR_DOWN;
      DIR_DOWN: reverse_dir = DIR_UP;
      DIR_LEFT: reverse_dir = DIR_RIGHT;
      default:  reverse_dir = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_key_decoder.sv
// rtl/snake_key_decoder.sv - PS/2 scancode to direction/restart strobes
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   rx_data, read_data  : scancode byte and its one-cycle valid strobe
//   dir_valid, dir      : direction key strobe and decoded direction
//   restart             : Enter key strobe
// The strobes are combinational from the current byte so a key acts on
// the same clock edge that samples read_data.
module snake_key_decoder
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       read_data,
  output logic       dir_valid,
  output dir_t       dir,
  output logic       restart
);

  // Set by a break prefix; the following byte is the released key and is dropped.
  logic skip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip <= 1'b0;
    end else if (read_data) begin
      if (skip) begin
        skip <= 1'b0;
      end else if (rx_data == SC_BREAK) begin
        skip <= 1'b1;
      end
    end
  end

  always_comb begin
    dir_valid = 1'b0;
    dir       = DIR_RIGHT;
    restart   = 1'b0;
    if (read_data && !skip) begin
      case (rx_data)
        SC_W:     begin dir_valid = 1'b1; dir = DIR_UP;    end
        SC_S:     begin dir_valid = 1'b1; dir = DIR_DOWN;  end
        SC_A:     begin dir_valid = 1'b1; dir = DIR_LEFT;  end
        SC_D:     begin dir_valid = 1'b1; dir = DIR_RIGHT; end
        SC_ENTER: restart = 1'b1;
        SC_EXT:   ;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake game engine: key control, timed moves, growth, collisions
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   rx_data, read_data  : PS/2 scancode byte and one-cycle valid strobe
//   x_values, y_values  : per-slot tile coordinates, slot i at [32*i +: 32], slot 0 = head,
//                         slots at or beyond length read all-ones
//   game_done           : high while the game is over
//   length              : live segment count
// Build option: define SNAKE_WRAP_EN to wrap the head around the grid edges
// instead of ending the game when it leaves the grid.
module snake_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN     = 100,
  parameter int GRID_W      = 10,
  parameter int GRID_H      = 10,
  parameter int STEP_CYCLES = 25_000_000,
  parameter int GROW_STEPS  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   read_data,
  output logic [32*MAX_LEN-1:0]  x_values,
  output logic [32*MAX_LEN-1:0]  y_values,
  output logic                   game_done,
  output logic [7:0]             length
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int GW = (GROW_STEPS > 1) ? $clog2(GROW_STEPS) : 1;
  localparam logic [TW-1:0] STEP_TC   = TW'(STEP_CYCLES - 1);
  localparam logic [GW-1:0] GROW_TC   = GW'(GROW_STEPS - 1);
  localparam logic [7:0]    MAX_LEN_L = 8'(MAX_LEN);
  localparam logic [31:0]   GRID_W_M1 = 32'(GRID_W - 1);
  localparam logic [31:0]   GRID_H_M1 = 32'(GRID_H - 1);

  function automatic logic [32*MAX_LEN-1:0] init_x();
    logic [32*MAX_LEN-1:0] v;
    v = '1;
    v[31:0]  = INIT_X0;
    v[63:32] = INIT_X1;
    v[95:64] = INIT_X2;
    return v;
  endfunction

  function automatic logic [32*MAX_LEN-1:0] init_y();
    logic [32*MAX_LEN-1:0] v;
    v = '1;
    v[31:0]  = INIT_Y;
    v[63:32] = INIT_Y;
    v[95:64] = INIT_Y;
    return v;
  endfunction

  logic          key_valid;
  dir_t          key_dir;
  logic          restart;

  state_t        state;
  logic [TW-1:0] timer;
  logic [GW-1:0] move_cnt;
  dir_t          dir;
  dir_t          pending_dir;

  snake_key_decoder u_key_decoder (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .read_data (read_data),
    .dir_valid (key_valid),
    .dir       (key_dir),
    .restart   (restart)
  );

  logic        move_now;
  dir_t        eff_dir;
  logic [31:0] hx, hy, nx, ny;
  logic        edge_hit, wall_hit, body_hit, grow_now;
  logic [7:0]  new_len;
  int          body_lim;

  always_comb begin
    move_now = (state == ST_RUN) && (timer == STEP_TC);
    // A key arriving on a move edge is judged against the direction that move applies.
    eff_dir  = move_now ? pending_dir : dir;

    hx       = x_values[31:0];
    hy       = y_values[31:0];
    nx       = hx;
    ny       = hy;
    edge_hit = 1'b0;
    case (pending_dir)
      DIR_UP: begin
        if (hy == 32'd0) begin ny = GRID_H_M1; edge_hit = 1'b1; end
        else ny = hy - 32'd1;
      end
      DIR_DOWN: begin
        if (hy == GRID_H_M1) begin ny = 32'd0; edge_hit = 1'b1; end
        else ny = hy + 32'd1;
      end
      DIR_LEFT: begin
        if (hx == 32'd0) begin nx = GRID_W_M1; edge_hit = 1'b1; end
        else nx = hx - 32'd1;
      end
      default: begin
        if (hx == GRID_W_M1) begin nx = 32'd0; edge_hit = 1'b1; end
        else nx = hx + 32'd1;
      end
    endcase
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
`else
    wall_hit = edge_hit;
`endif

    grow_now = (move_cnt == GROW_TC) && (length < MAX_LEN_L);
    new_len  = grow_now ? length + 8'd1 : length;

    // The tail vacates its tile on a plain move, so it only blocks on growth.
    body_lim = grow_now ? int'(length) : int'(length) - 1;
    body_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < body_lim) && (x_values[32*i +: 32] == nx) && (y_values[32*i +: 32] == ny)) begin
        body_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      move_cnt    <= '0;
      dir         <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      length      <= INIT_LEN;
      x_values    <= init_x();
      y_values    <= init_y();
      game_done   <= 1'b0;
    end else if (restart) begin
      state       <= ST_IDLE;
      timer       <= '0;
      move_cnt    <= '0;
      dir         <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      length      <= INIT_LEN;
      x_values    <= init_x();
      y_values    <= init_y();
      game_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid && (key_dir != reverse_dir(dir))) begin
            pending_dir <= key_dir;
            state       <= ST_RUN;
            timer       <= '0;
          end
        end
        ST_RUN: begin
          if (key_valid && (key_dir != reverse_dir(eff_dir))) begin
            pending_dir <= key_dir;
          end
          if (move_now) begin
            timer <= '0;
            dir   <= pending_dir;
            if (wall_hit || body_hit) begin
              // Arrays keep their pre-move contents.
              state     <= ST_DONE;
              game_done <= 1'b1;
            end else begin
              length   <= new_len;
              move_cnt <= (move_cnt == GROW_TC) ? '0 : move_cnt + GW'(1);
              x_values[31:0] <= nx;
              y_values[31:0] <= ny;
              for (int i = 1; i < MAX_LEN; i++) begin
                if (i < int'(new_len)) begin
                  x_values[32*i +: 32] <= x_values[32*(i-1) +: 32];
                  y_values[32*i +: 32] <= y_values[32*(i-1) +: 32];
                end
              end
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 Parameter MAX_LEN, 100, segment slots in each output array; 32 bits per slot.
REQ-002 Parameter GRID_W, 10, tile columns 0..GRID_W-1.
REQ-003 Parameter GRID_H, 10, tile rows 0..GRID_H-1.
REQ-004 Parameter STEP_CYCLES, 25_000_000, clk cycles per snake move.
REQ-005 Parameter GROW_STEPS, 8, moves between length increments.
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 rx_data  input  8  PS/2 scancode byte.
REQ-009 read_data  input  1  one-cycle strobe, rx_data valid.
REQ-010 x_values  output  32*MAX_LEN  tile x of segment i at bits [32*i +: 32]; slot 0 = head.
REQ-011 y_values  output  32*MAX_LEN  tile y, same layout.
REQ-012 game_done  output  1  high while in DONE.
REQ-013 length  output  8  live segment count.

Function
REQ-014 States: IDLE, RUN, DONE; all outputs registered.
REQ-015 Unused slots (i >= length) SHALL read 32'hFFFFFFFF in both arrays.
REQ-016 Key decode: 8'hF0 arms break-skip, next byte ignored; 8'hE0 ignored; W=8'h1D up, S=8'h1B down, A=8'h1C left, D=8'h23 right, Enter=8'h5A restart.
REQ-017 Direction key sets pending_dir unless it is the reverse of applied dir; reverse keys dropped.
REQ-018 IDLE -> RUN on first accepted direction key; step timer cleared on entry.
REQ-019 In RUN, timer counts 0..STEP_CYCLES-1; move executes on the terminal-count cycle; arrays update at that edge.
REQ-020 Move: dir <= pending_dir; new head = head +/-1 on axis; slot i <= slot i-1 for i in 1..length-1.
REQ-021 Growth: every GROW_STEPS-th move, length += 1 (saturating at MAX_LEN) and old tail kept in slot length.
REQ-022 Self-collision: new head equal to any slot 0..length-2 (0..length-1 on a growth move) -> DONE, arrays frozen at pre-move values.
REQ-023 Key strobe on a move cycle: move uses prior pending_dir; new key applies to next move.
REQ-024 DONE: ignores direction keys; Enter -> IDLE with initial snake reloaded.
REQ-025 Enter in RUN SHALL also restart to IDLE.
REQ-026 x-coordinate arithmetic in 32 bits, values always within 0..GRID_W-1 / 0..GRID_H-1 unless DONE.

Reset
REQ-027 Reset SHALL force IDLE, timer 0, break-skip clear, dir=pending_dir=RIGHT, length=3, slots 0..2 = (4,5),(3,5),(2,5), others all-ones, game_done=0.
REQ-028 Reset mid-move SHALL win; no partial array update is visible.

Configuration
REQ-029 Macro SNAKE_WRAP_EN defined: head leaving grid wraps (x=GRID_W -> 0, x=-1 -> GRID_W-1, same for y); game ends only on self-collision.
REQ-030 SNAKE_WRAP_EN undefined: head leaving grid -> DONE, arrays frozen.

Structure
REQ-031 Package snake_pkg SHALL hold direction and state enums, scancode constants, EMPTY_SLOT=32'hFFFFFFFF, initial-snake constants.
REQ-032 Sub-module snake_key_decoder SHALL convert rx_data/read_data into dir_valid, dir, restart strobes with break-skip.

Verification
REQ-033 Reset, no keys for 3*STEP_CYCLES -> state IDLE, slot0=(4,5), slot3 all-ones, game_done=0.
REQ-034 Send 8'h1D in IDLE, wait one step -> head (4,4), slot1=(4,5), slot2=(3,5).
REQ-035 RUN moving right, send 8'h1C (left) -> ignored, next head x increments.
REQ-036 Send 8'hF0 then 8'h1D -> no direction change.
REQ-037 Wrap off: head (9,5) moving right, one step -> game_done=1, slot0 stays (9,5); wrap on: slot0=(0,5).
REQ-038 After GROW_STEPS moves -> length=4, slot3 = previous tail; forced U-turn loop into body -> game_done=1, Enter -> IDLE, initial snake.
